// File: rtl/mem_access_unit.sv
// MEM-stage data access: drives a valid/ready data-memory transaction,
// steers store lanes, extends load data and stalls the pipeline while busy.
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read_m,
   input  logic        mem_write_m,
   input  logic [2:0]  funct3_m,
   input  logic [31:0] alu_result_m,
   input  logic [31:0] write_data_m,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] read_data_m,
   output logic        stall_m,
   output logic        misaligned_m,
   output logic        timeout_m
);

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   logic [7:0]  cnt;
   logic [7:0]  cnt_inc;
   logic [2:0]  f3_q;
   logic [1:0]  alo_q;

   logic        access;
   logic        fault;
   logic        is_half;
   logic        is_word;
   logic [3:0]  be_c;
   logic [31:0] wdata_c;
   logic [7:0]  byte_c;
   logic [15:0] half_c;
   logic [31:0] load_c;

   always_comb begin
      access  = mem_read_m | mem_write_m;
      is_half = (funct3_m[1:0] == 2'b01);
      is_word = (funct3_m == 3'd2);
      fault   = access & ((mem_read_m & mem_write_m)
                | (funct3_m == 3'd3) | (funct3_m == 3'd6) | (funct3_m == 3'd7)
                | (mem_write_m & (funct3_m > 3'd2))
                | (is_half & alu_result_m[0])
                | (is_word & (alu_result_m[1:0] != 2'b00)));
   end

   always_comb begin
      be_c    = 4'b1111;
      wdata_c = write_data_m;
      case (funct3_m[1:0])
         2'b00: begin
            be_c    = 4'b0001 << alu_result_m[1:0];
            wdata_c = {4{write_data_m[7:0]}};
         end
         2'b01: begin
            be_c    = alu_result_m[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{write_data_m[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      byte_c = dmem_rdata[{alo_q, 3'b000} +: 8];
      half_c = alo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (f3_q)
         3'd0:    load_c = {{24{byte_c[7]}}, byte_c};
         3'd4:    load_c = {24'd0, byte_c};
         3'd1:    load_c = {{16{half_c[15]}}, half_c};
         3'd5:    load_c = {16'd0, half_c};
         default: load_c = dmem_rdata;
      endcase
   end

   assign cnt_inc      = cnt + 8'd1;
   assign misaligned_m = (state == IDLE) & fault;
   assign stall_m      = ((state == IDLE) & access & ~fault) | (state == BUSY);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= '0;
         f3_q        <= '0;
         alo_q       <= '0;
         dmem_req    <= 1'b0;
         dmem_we     <= 1'b0;
         dmem_addr   <= '0;
         dmem_be     <= '0;
         dmem_wdata  <= '0;
         read_data_m <= '0;
         timeout_m   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               timeout_m <= 1'b0;
               if (access & ~fault) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= mem_write_m;
                  dmem_addr  <= {alu_result_m[31:2], 2'b00};
                  dmem_be    <= be_c;
                  dmem_wdata <= wdata_c;
                  f3_q       <= funct3_m;
                  alo_q      <= alu_result_m[1:0];
                  cnt        <= '0;
                  state      <= BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt_inc;
               // A ready on the final allowed cycle still completes normally.
               if (dmem_ready) begin
                  dmem_req  <= 1'b0;
                  timeout_m <= 1'b0;
                  if (!dmem_we) read_data_m <= load_c;
                  state     <= DONE;
               end else if (cnt_inc == TIMEOUT_LIMIT) begin
                  dmem_req  <= 1'b0;
                  timeout_m <= 1'b1;
                  if (!dmem_we) read_data_m <= '0;
                  state     <= DONE;
               end
            end
            DONE: begin
               timeout_m <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table for single accesses plus
// hand sequences for reset, timeout and out-of-BUSY ready.
module tb_mem_access_unit;

   logic        clk;
   logic        reset;
   logic        mem_read_m;
   logic        mem_write_m;
   logic [2:0]  funct3_m;
   logic [31:0] alu_result_m;
   logic [31:0] write_data_m;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic [31:0] read_data_m;
   logic        stall_m;
   logic        misaligned_m;
   logic        timeout_m;

   int checks = 0;
   int errors = 0;

   mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .mem_read_m   (mem_read_m),
      .mem_write_m  (mem_write_m),
      .funct3_m     (funct3_m),
      .alu_result_m (alu_result_m),
      .write_data_m (write_data_m),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_be      (dmem_be),
      .dmem_wdata   (dmem_wdata),
      .dmem_ready   (dmem_ready),
      .dmem_rdata   (dmem_rdata),
      .read_data_m  (read_data_m),
      .stall_m      (stall_m),
      .misaligned_m (misaligned_m),
      .timeout_m    (timeout_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rdata;
      int          ready_at;
      logic        fault;
      logic [3:0]  be;
      logic [31:0] exp_addr;
      logic [31:0] wdata;
      logic [31:0] rdm;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      mem_read_m   = 1'b0;
      mem_write_m  = 1'b0;
      funct3_m     = 3'd0;
      alu_result_m = '0;
      write_data_m = '0;
   endtask

   logic [31:0] exp_rdm;
   int          nreq;
   vec_t        v;

   initial begin
      //            rd wr f3    addr          wd            rdata         rdy flt be     exp_addr      wdata         rdm
      vecs[0]  = '{1'b1,1'b0,3'd2,32'h0000_1004,32'h0,        32'hDEADBEEF,2, 1'b0,4'b1111,32'h0000_1004,32'h0,        32'hDEADBEEF};
      vecs[1]  = '{1'b1,1'b0,3'd0,32'h0000_3003,32'h0,        32'h80FF7F01,1, 1'b0,4'b1000,32'h0000_3000,32'h0,        32'hFFFFFF80};
      vecs[2]  = '{1'b1,1'b0,3'd4,32'h0000_3003,32'h0,        32'h80FF7F01,1, 1'b0,4'b1000,32'h0000_3000,32'h0,        32'h00000080};
      vecs[3]  = '{1'b1,1'b0,3'd1,32'h0000_3002,32'h0,        32'h80FF7F01,1, 1'b0,4'b1100,32'h0000_3000,32'h0,        32'hFFFF80FF};
      vecs[4]  = '{1'b1,1'b0,3'd5,32'h0000_3000,32'h0,        32'h80FF7F01,1, 1'b0,4'b0011,32'h0000_3000,32'h0,        32'h00007F01};
      vecs[5]  = '{1'b1,1'b0,3'd0,32'h0000_3001,32'h0,        32'h80FF7F01,2, 1'b0,4'b0010,32'h0000_3000,32'h0,        32'h0000007F};
      vecs[6]  = '{1'b0,1'b1,3'd1,32'h0000_2002,32'h1234ABCD,32'h55555555,1, 1'b0,4'b1100,32'h0000_2000,32'hABCDABCD,32'h0};
      vecs[7]  = '{1'b0,1'b1,3'd0,32'h0000_2001,32'h000000A5,32'h0,        3, 1'b0,4'b0010,32'h0000_2000,32'hA5A5A5A5,32'h0};
      vecs[8]  = '{1'b0,1'b1,3'd2,32'h0000_2008,32'hCAFEF00D,32'h0,        4, 1'b0,4'b1111,32'h0000_2008,32'hCAFEF00D,32'h0};
      vecs[9]  = '{1'b1,1'b0,3'd2,32'h0000_1001,32'h0,        32'h0,        0, 1'b1,4'b0000,32'h0,        32'h0,        32'h0};
      vecs[10] = '{1'b1,1'b0,3'd1,32'h0000_1003,32'h0,        32'h0,        0, 1'b1,4'b0000,32'h0,        32'h0,        32'h0};
      vecs[11] = '{1'b0,1'b1,3'd4,32'h0000_2000,32'h0,        32'h0,        0, 1'b1,4'b0000,32'h0,        32'h0,        32'h0};
      vecs[12] = '{1'b1,1'b1,3'd2,32'h0000_2000,32'h0,        32'h0,        0, 1'b1,4'b0000,32'h0,        32'h0,        32'h0};
      vecs[13] = '{1'b1,1'b0,3'd3,32'h0000_2000,32'h0,        32'h0,        0, 1'b1,4'b0000,32'h0,        32'h0,        32'h0};
      vecs[14] = '{1'b1,1'b0,3'd2,32'h0000_1000,32'h0,        32'h12345678,4, 1'b0,4'b1111,32'h0000_1000,32'h0,        32'h12345678};
      vecs[15] = '{1'b1,1'b0,3'd1,32'h0000_3000,32'h0,        32'h00008001,1, 1'b0,4'b0011,32'h0000_3000,32'h0,        32'hFFFF8001};
      vecs[16] = '{1'b0,1'b1,3'd2,32'h0000_2002,32'h0,        32'h0,        0, 1'b1,4'b0000,32'h0,        32'h0,        32'h0};

      // Reset state, with a legal lw presented so stall_m shows its combinational value
      reset        = 1'b0;
      idle_inputs();
      mem_read_m   = 1'b1;
      funct3_m     = 3'd2;
      alu_result_m = 32'h0000_1000;
      dmem_ready   = 1'b0;
      dmem_rdata   = '0;
      #2;
      chk("rst_req",    dmem_req,    0);
      chk("rst_we",     dmem_we,     0);
      chk("rst_addr",   dmem_addr,   0);
      chk("rst_be",     dmem_be,     0);
      chk("rst_wdata",  dmem_wdata,  0);
      chk("rst_rdm",    read_data_m, 0);
      chk("rst_tmo",    timeout_m,   0);
      chk("rst_stall",  stall_m,     1);
      chk("rst_misal",  misaligned_m,0);
      idle_inputs();
      @(posedge clk); #1;
      reset = 1'b1;

      // Reset asserted in the 2nd BUSY cycle
      @(posedge clk); #1;
      mem_read_m   = 1'b1;
      funct3_m     = 3'd2;
      alu_result_m = 32'h0000_1008;
      dmem_rdata   = 32'h11111111;
      @(posedge clk); #2;
      chk("mid_busy1_req", dmem_req, 1);
      @(posedge clk); #1;
      dmem_ready = 1'b1;
      reset      = 1'b0;
      #1;
      chk("mid_rst_req",  dmem_req,    0);
      chk("mid_rst_addr", dmem_addr,   0);
      idle_inputs();
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("post_rst_stall", stall_m,     0);
      chk("post_rst_rdm",   read_data_m, 0);
      @(posedge clk); #2;
      chk("post_rst_req",   dmem_req,    0);
      chk("post_rst_rdm2",  read_data_m, 0);
      chk("post_rst_stall2",stall_m,     0);
      dmem_ready = 1'b0;
      exp_rdm    = '0;

      for (int i = 0; i < NV; i++) begin
         v = vecs[i];
         @(posedge clk); #1;
         mem_read_m   = v.rd;
         mem_write_m  = v.wr;
         funct3_m     = v.f3;
         alu_result_m = v.addr;
         write_data_m = v.wd;
         dmem_rdata   = v.rdata;
         dmem_ready   = 1'b0;
         #1;
         chk($sformatf("v%0d_misal", i), misaligned_m, v.fault);
         chk($sformatf("v%0d_stall0", i), stall_m, !v.fault);
         if (v.fault) begin
            repeat (2) begin
               @(posedge clk); #2;
               chk($sformatf("v%0d_fault_req", i), dmem_req, 0);
               chk($sformatf("v%0d_fault_stall", i), stall_m, 0);
               chk($sformatf("v%0d_fault_misal", i), misaligned_m, 1);
            end
            idle_inputs();
         end else begin
            for (int c = 1; c <= v.ready_at; c++) begin
               @(posedge clk); #1;
               dmem_ready = (c == v.ready_at);
               #1;
               chk($sformatf("v%0d_c%0d_req", i, c),   dmem_req,   1);
               chk($sformatf("v%0d_c%0d_stall", i, c), stall_m,    1);
               chk($sformatf("v%0d_c%0d_we", i, c),    dmem_we,    v.wr);
               chk($sformatf("v%0d_c%0d_addr", i, c),  dmem_addr,  v.exp_addr);
               chk($sformatf("v%0d_c%0d_be", i, c),    dmem_be,    v.be);
               chk($sformatf("v%0d_c%0d_wdata", i, c), dmem_wdata, v.wdata);
            end
            @(posedge clk); #1;
            dmem_ready = 1'b0;
            idle_inputs();
            #1;
            if (v.rd) exp_rdm = v.rdm;
            chk($sformatf("v%0d_done_req", i),   dmem_req,    0);
            chk($sformatf("v%0d_done_stall", i), stall_m,     0);
            chk($sformatf("v%0d_done_rdm", i),   read_data_m, exp_rdm);
            chk($sformatf("v%0d_done_tmo", i),   timeout_m,   0);
         end
      end

      // Timeout: ready held low, expect exactly 4 request cycles
      @(posedge clk); #1;
      mem_read_m   = 1'b1;
      funct3_m     = 3'd2;
      alu_result_m = 32'h0000_4000;
      dmem_rdata   = 32'hFFFFFFFF;
      dmem_ready   = 1'b0;
      nreq = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #2;
         if (dmem_req) nreq++;
         else break;
      end
      chk("tmo_req_cycles", nreq,        4);
      chk("tmo_flag",       timeout_m,   1);
      chk("tmo_rdm",        read_data_m, 0);
      chk("tmo_stall",      stall_m,     0);
      idle_inputs();
      @(posedge clk); #2;
      chk("tmo_flag_clear", timeout_m,   0);
      chk("tmo_req_idle",   dmem_req,    0);

      // Ready while IDLE must not start or complete anything
      dmem_ready = 1'b1;
      dmem_rdata = 32'hA5A5A5A5;
      repeat (2) begin
         @(posedge clk); #2;
         chk("idle_ready_req", dmem_req,    0);
         chk("idle_ready_rdm", read_data_m, 0);
      end
      dmem_ready = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
